// File: rtl/rv_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Define MULDIV_EARLY_OUT_EN to finish zero-operand multiplies and |a|<|b| divides without iterating.
module rv_muldiv_unit #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    localparam int unsigned W2 = 2 * XLEN;

    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [2:0]        f3_q, f3_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
        return ~v + XLEN'(1);
    endfunction

    // Operand decode: signedness, magnitudes and the no-iteration shortcuts.
    logic            a_signed_c, b_signed_c;
    logic            sgn_a_c, sgn_b_c;
    logic [XLEN-1:0] abs_a_c, abs_b_c;
    logic            special_c;
    logic [XLEN-1:0] special_res_c;

    always_comb begin
        a_signed_c    = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                        (funct3 == F_DIV)  || (funct3 == F_REM);
        b_signed_c    = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
        sgn_a_c       = a_signed_c && op_a[XLEN-1];
        sgn_b_c       = b_signed_c && op_b[XLEN-1];
        abs_a_c       = sgn_a_c ? negate(op_a) : op_a;
        abs_b_c       = sgn_b_c ? negate(op_b) : op_b;
        special_c     = 1'b0;
        special_res_c = '0;
        if (funct3[2]) begin
            if (op_b == '0) begin
                special_c     = 1'b1;
                special_res_c = funct3[1] ? op_a : '1;
            end else if (!funct3[0] && (op_a == MIN_NEG) && (op_b == '1)) begin
                special_c     = 1'b1;
                special_res_c = funct3[1] ? '0 : op_a;
            end
`ifdef MULDIV_EARLY_OUT_EN
            else if (abs_a_c < abs_b_c) begin
                special_c     = 1'b1;
                special_res_c = funct3[1] ? op_a : '0;
            end
`endif
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if ((op_a == '0) || (op_b == '0)) begin
            special_c     = 1'b1;
            special_res_c = '0;
        end
`endif
    end

    // One radix-2 step for each operation, and the sign/half selection applied in FIX.
    logic [XLEN-1:0] mul_addend_c;
    logic [XLEN:0]   mul_sum_c;
    logic [W2-1:0]   mul_next_c;
    logic [XLEN:0]   div_shift_c, div_diff_c;
    logic            div_ge_c;
    logic [W2-1:0]   div_next_c;
    logic [W2-1:0]   prod_fix_c;
    logic [XLEN-1:0] quo_c, rem_c;
    logic [XLEN-1:0] fix_res_c;

    always_comb begin
        mul_addend_c = acc_q[0] ? opnd_q : '0;
        mul_sum_c    = {1'b0, acc_q[W2-1:XLEN]} + {1'b0, mul_addend_c};
        mul_next_c   = {mul_sum_c, acc_q[XLEN-1:1]};

        // {remainder, next dividend bit} minus divisor; borrow out means "does not fit".
        div_shift_c  = acc_q[W2-1:XLEN-1];
        div_diff_c   = div_shift_c - {1'b0, opnd_q};
        div_ge_c     = !div_diff_c[XLEN];
        div_next_c   = {(div_ge_c ? div_diff_c[XLEN-1:0] : div_shift_c[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ge_c};

        prod_fix_c   = (neg_a_q ^ neg_b_q) ? (~acc_q + W2'(1)) : acc_q;
        quo_c        = acc_q[XLEN-1:0];
        rem_c        = acc_q[W2-1:XLEN];
        if (f3_q[2]) begin
            if (f3_q[1]) fix_res_c = neg_a_q ? negate(rem_c) : rem_c;
            else         fix_res_c = (neg_a_q ^ neg_b_q) ? negate(quo_c) : quo_c;
        end else begin
            fix_res_c = (f3_q[1:0] == 2'b00) ? prod_fix_c[XLEN-1:0] : prod_fix_c[W2-1:XLEN];
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        f3_d     = f3_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (!flush && start) begin
                    if (special_c) begin
                        result_d = special_res_c;
                        state_d  = S_DONE;
                    end else begin
                        f3_d    = funct3;
                        neg_a_d = sgn_a_c;
                        neg_b_d = sgn_b_c;
                        cnt_d   = CNT_W'(XLEN - 1);
                        state_d = S_CALC;
                        if (funct3[2]) begin
                            opnd_d = abs_b_c;
                            acc_d  = {{XLEN{1'b0}}, abs_a_c};
                        end else begin
                            opnd_d = abs_a_c;
                            acc_d  = {{XLEN{1'b0}}, abs_b_c};
                        end
                    end
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = f3_q[2] ? div_next_c : mul_next_c;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == '0) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    result_d = fix_res_c;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            f3_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            f3_q     <= f3_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Randomized + directed bench for rv_muldiv_unit against a 128-bit arithmetic reference.
module tb_rv_muldiv_unit;

    localparam int unsigned XLEN = 64;
    localparam logic [63:0] MIN_NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL1    = 64'hFFFF_FFFF_FFFF_FFFF;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [63:0] op_a, op_b;
    logic [63:0] result;
    logic        busy, done;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] last_exp = '0;

    rv_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .flush  (flush),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics with wide plain arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] f, input logic [63:0] a,
                                               input logic [63:0] b);
        logic signed [127:0] p;
        logic signed [63:0]  sa, sb;
        logic                ovf;
        sa  = a;
        sb  = b;
        ovf = (a == MIN_NEG) && (b == ALL1);
        case (f)
            MUL:    return a * b;
            MULH:   begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); return p[127:64]; end
            MULHSU: begin p = $signed({{64{a[63]}}, a}) * $signed({64'b0, b});     return p[127:64]; end
            MULHU:  begin p = $signed({64'b0, a}) * $signed({64'b0, b});           return p[127:64]; end
            DIV:    return (b == 0) ? ALL1 : ovf ? a : 64'(sa / sb);
            DIVU:   return (b == 0) ? ALL1 : a / b;
            REM:    return (b == 0) ? a : ovf ? 64'd0 : 64'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b);
        logic       sgn;
        logic [63:0] ma, mb;
        sgn = !f[0];
        ma  = (sgn && a[63]) ? -a : a;
        mb  = (sgn && b[63]) ? -b : b;
        if (f[2] && (b == 0)) return 1;
        if ((f == DIV || f == REM) && a == MIN_NEG && b == ALL1) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!f[2] && (a == 0 || b == 0)) return 1;
        if (f[2] && ma < mb) return 1;
`else
        if (ma == mb) return XLEN + 2;
`endif
        return XLEN + 2;
    endfunction

    // Called at the negedge of cycle 1 of an accepted operation.
    task automatic wait_done(input string tag, input int exp_lat, input logic [63:0] exp_res);
        int cyc    = 1;
        int busy_n = 0;
        int dcyc   = 0;
        while (cyc <= 200) begin
            if (busy) busy_n++;
            if (done) begin
                dcyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_latency"}, 64'(dcyc), 64'(exp_lat));
        check_eq({tag, "_busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        check_eq({tag, "_result"}, result, exp_res);
        last_exp = exp_res;
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 64'(done), 64'(start ? 1'b0 : 1'b0));
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [63:0] a,
                          input logic [63:0] b);
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, ref_latency(f, a, b), ref_result(f, a, b));
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return ALL1;
            2: return MIN_NEG;
            3: return 64'($urandom_range(0, 20));
            4: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int pulses;
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_result", result, 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        reset = 1'b0;

        run_op("mul_7_m3", MUL, 64'd7, -64'd3);
        check_eq("mul_7_m3_const", last_exp, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mulhu_ones", MULHU, ALL1, ALL1);
        check_eq("mulhu_const", last_exp, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulh_ones", MULH, ALL1, ALL1);
        run_op("div_m7_2", DIV, -64'd7, 64'd2);
        check_eq("div_const", last_exp, -64'd3);
        run_op("rem_m7_2", REM, -64'd7, 64'd2);
        run_op("divu_by0", DIVU, 64'd100, 64'd0);
        run_op("remu_by0", REMU, 64'd100, 64'd0);
        run_op("div_ovf", DIV, MIN_NEG, ALL1);
        run_op("rem_ovf", REM, MIN_NEG, ALL1);
        run_op("mul_zero", MUL, 64'd0, 64'd5);
        run_op("divu_small", DIVU, 64'd3, 64'd10);

        // Flush in the middle of a divide: no done, result untouched.
        @(negedge clk);
        start = 1'b1; funct3 = DIVU; op_a = 64'd1000; op_b = 64'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy", 64'(busy), 64'd0);
        pulses = 0;
        repeat (70) begin
            if (done) pulses++;
            @(negedge clk);
        end
        check_eq("flush_no_done", 64'(pulses), 64'd0);
        check_eq("flush_result_kept", result, last_exp);

        // Asynchronous reset mid-operation.
        start = 1'b1; funct3 = DIVU; op_a = 64'd1000; op_b = 64'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("areset_busy", 64'(busy), 64'd0);
        check_eq("areset_result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        last_exp = '0;

        // Back-to-back: start held, second request accepted in the DONE cycle.
        @(negedge clk);
        start = 1'b1; funct3 = MUL; op_a = 64'd3; op_b = 64'd5;
        @(negedge clk);
        funct3 = MULHSU; op_a = ALL1; op_b = 64'd2;
        begin
            int cyc = 1;
            while (cyc <= 200 && !done) begin
                @(negedge clk);
                cyc++;
            end
            check_eq("b2b_first_latency", 64'(cyc), 64'(XLEN + 2));
            check_eq("b2b_first_result", result, 64'd15);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done("b2b_second", ref_latency(MULHSU, ALL1, 64'd2), ref_result(MULHSU, ALL1, 64'd2));
        check_eq("b2b_second_const", last_exp, ALL1);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f;
            logic [63:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = rand_operand();
            b = rand_operand();
            run_op($sformatf("rand%0d_f%0d", i, f), f, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=%h exp=%h", 64'd1, 64'd0);
        $fatal(1, "timeout");
    end

endmodule
